// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Purpose  : Serial scan driver for a multiplexed hex 7-segment display
//            (segment byte + one-hot select byte per digit, shift/latch clocks).
//            Optional SEG_SCAN_LZB_EN enables leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  blank,
  output logic                  ds,
  output logic                  shclk,
  output logic                  stclk
);

  logic [DIV_W-1:0]    r_div;
  logic [3:0]          r_bit;
  logic [2:0]          r_digit;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp;
  logic [4*DIGITS-1:0] r_buf_data;
  logic [DIGITS-1:0]   r_buf_dp;
  logic [15:0]         r_frame;
  logic                r_ds;
  logic                r_shclk;
  logic                r_stclk;

  logic                w_period_start;
  logic                w_frame_start;
  logic                w_commit;
  logic [4*DIGITS-1:0] w_cur_data;
  logic [DIGITS-1:0]   w_cur_dp;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_lz;
  logic [7:0]          w_seg;
  logic [7:0]          w_sel;
  logic [15:0]         w_frame;

  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 8'h03;
      4'h1: seg_code = 8'h9F;
      4'h2: seg_code = 8'h25;
      4'h3: seg_code = 8'h0D;
      4'h4: seg_code = 8'h99;
      4'h5: seg_code = 8'h49;
      4'h6: seg_code = 8'h41;
      4'h7: seg_code = 8'h1F;
      4'h8: seg_code = 8'h01;
      4'h9: seg_code = 8'h09;
      4'hA: seg_code = 8'h11;
      4'hB: seg_code = 8'hC1;
      4'hC: seg_code = 8'h63;
      4'hD: seg_code = 8'h85;
      4'hE: seg_code = 8'h61;
      default: seg_code = 8'h71;
    endcase
  endfunction

  assign w_period_start = (r_div == '0);
  assign w_frame_start  = w_period_start && (r_bit == 4'd0);
  assign w_commit       = w_frame_start && (r_digit == 3'd0) && r_pending;

  // The digit-0 frame that commits a pending update already shows the new value,
  // so a whole scan is always drawn from one consistent buffer.
  assign w_cur_data = w_commit ? r_sh_data : r_buf_data;
  assign w_cur_dp   = w_commit ? r_sh_dp   : r_buf_dp;

  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_digit == 3'(k)) begin
        w_nib    = w_cur_data[4*k +: 4];
        w_dp_bit = w_cur_dp[k];
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Blank when this digit and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_lz = (r_digit != 3'd0);
    for (int j = 0; j < DIGITS; j++) begin
      if ((3'(j) >= r_digit) && (w_cur_data[4*j +: 4] != 4'h0)) w_lz = 1'b0;
    end
  end
`else
  assign w_lz = 1'b0;
`endif

  always_comb begin
    w_seg = (w_lz ? 8'hFF : seg_code(w_nib)) & ~{7'd0, w_dp_bit};
    if (blank) w_seg = 8'hFF;
  end

  assign w_sel   = 8'd1 << r_digit;
  assign w_frame = {w_sel, w_seg};

  // Outputs are registered from the current scan position, so each output cycle
  // reflects the position the counters held on the preceding edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= '0;
      r_bit      <= 4'd0;
      r_digit    <= 3'd0;
      r_pending  <= 1'b0;
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_buf_data <= '0;
      r_buf_dp   <= '0;
      r_frame    <= 16'd0;
      r_ds       <= 1'b0;
      r_shclk    <= 1'b0;
      r_stclk    <= 1'b0;
    end else begin
      r_shclk <= r_div[DIV_W-1];
      r_stclk <= (r_bit == 4'd0);
      if (w_frame_start) begin
        r_frame <= w_frame;
        r_ds    <= w_frame[0];
      end else if (w_period_start) begin
        r_ds <= r_frame[r_bit];
      end

      r_div <= r_div + DIV_W'(1);
      if (&r_div) begin
        r_bit <= r_bit + 4'd1;
        if (r_bit == 4'd15) begin
          r_digit <= (r_digit == 3'(DIGITS-1)) ? 3'd0 : r_digit + 3'd1;
        end
      end

      if (w_commit) begin
        r_buf_data <= r_sh_data;
        r_buf_dp   <= r_sh_dp;
        r_pending  <= 1'b0;
      end else if (in_valid && !r_pending) begin
        r_sh_data <= in_data;
        r_sh_dp   <= in_dp;
        r_pending <= 1'b1;
      end
    end
  end

  assign in_ready = ~r_pending;
  assign ds       = r_ds;
  assign shclk    = r_shclk;
  assign stclk    = r_stclk;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan
// Purpose  : Randomised scenario bench for seg_scan (DIGITS=4, DIV_W=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic        in_valid;
  logic        in_ready;
  logic        blank;
  logic        ds;
  logic        shclk;
  logic        stclk;

  int compared   = 0;
  int mismatched = 0;

  int          n;
  logic [15:0] m_buf;
  logic [3:0]  m_bdp;
  logic [15:0] m_sh;
  logic [3:0]  m_sdp;
  bit          m_pend;
  logic [15:0] m_frame;
  logic [15:0] cap;
  logic [15:0] cap_q[$];
  int          xfers;

  logic [7:0] tbl [0:15] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  seg_scan #(.DIGITS(4), .DIV_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_dp(in_dp), .in_valid(in_valid),
    .in_ready(in_ready), .blank(blank), .ds(ds), .shclk(shclk), .stclk(stclk)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mframe(input logic [15:0] d, input logic [3:0] dp,
                                         input int dig, input logic blk);
    logic [7:0] seg;
    logic [7:0] sel;
    int msnz;
    seg = tbl[d[4*dig +: 4]];
`ifdef SEG_SCAN_LZB_EN
    msnz = 0;
    for (int j = 0; j < 4; j++) if (d[4*j +: 4] != 4'h0) msnz = j;
    if (dig > msnz) seg = 8'hFF;
`else
    msnz = 0;
`endif
    if (dp[dig]) seg = seg & 8'hFE;
    if (blk) seg = 8'hFF;
    sel = 8'd1 << dig;
    return {sel, seg};
  endfunction

  // One clock of the reference: position n is the scan position sampled at this edge.
  task automatic step();
    logic [3:0] exp;
    if (in_valid && in_ready) xfers++;
    if ((n % 256 == 0) && m_pend) begin
      m_buf = m_sh; m_bdp = m_sdp; m_pend = 0;
    end else if (in_valid && !m_pend) begin
      m_sh = in_data; m_sdp = in_dp; m_pend = 1;
    end
    if (n % 64 == 0) m_frame = mframe(m_buf, m_bdp, (n / 64) % 4, blank);
    exp = {m_frame[(n / 4) % 16], (n % 4) >= 2, ((n / 4) % 16) == 0, !m_pend};
    @(posedge clk); #1;
    compared++;
    if ({ds, shclk, stclk, in_ready} !== exp) begin
      mismatched++;
      $display("FAIL scan n=%0d {ds,shclk,stclk,in_ready} got %b want %b", n,
               {ds, shclk, stclk, in_ready}, exp);
    end
    if (n % 4 == 2) cap[(n / 4) % 16] = ds;
    if (n % 64 == 63) cap_q.push_back(cap);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic test_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b1; blank = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({ds, shclk, stclk, in_ready} !== 4'b0001) begin
        mismatched++;
        $display("FAIL reset {ds,shclk,stclk,in_ready} got %b want 0001",
                 {ds, shclk, stclk, in_ready});
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    n = 0; m_buf = '0; m_bdp = '0; m_sh = '0; m_sdp = '0; m_pend = 0; m_frame = '0;
    cap_q.delete();
  endtask

  task automatic check_scan(input string name, input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3);
    logic [15:0] want [4];
    want = '{f0, f1, f2, f3};
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (cap_q.size() <= i || cap_q[i] !== want[i]) begin
        mismatched++;
        $display("FAIL %s frame%0d got %h want %h", name, i,
                 (cap_q.size() > i) ? cap_q[i] : 16'hxxxx, want[i]);
      end
    end
  endtask

  task automatic test_idle();
    run_to(256);
    check_scan("idle", 16'h0103, 16'h0203, 16'h0403, 16'h0803);
  endtask

  task automatic test_update();
    run_to(404);
    in_data = 16'h1234; in_dp = 4'b0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 16'hFFFF; in_dp = 4'hF;
    step();
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL update_ready got %b want 0", in_ready);
    end
    run_to(512);
    cap_q.delete();
    run_to(768);
    check_scan("update", 16'h0198, 16'h020D, 16'h0425, 16'h089F);
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    while (n < 1024) begin in_data = 16'($urandom); in_dp = 4'($urandom); step(); end
    xfers = 0;
    while (n < 1792) begin in_data = 16'($urandom); in_dp = 4'($urandom); step(); end
    in_valid = 1'b0;
    compared++;
    if (xfers !== 3) begin
      mismatched++;
      $display("FAIL back_to_back transfers got %0d want 3", xfers);
    end
  endtask

  task automatic test_blank();
    run_to(1886);
    blank = 1'b1;
    cap_q.delete();
    run_to(1984);
    blank = 1'b0;
    compared++;
    if (cap_q.size() != 2 || cap_q[0][15:8] !== 8'h02 || cap_q[0][7:0] === 8'hFF) begin
      mismatched++;
      $display("FAIL blank_current got %h want sel 02 with visible segments",
               (cap_q.size() > 0) ? cap_q[0] : 16'hxxxx);
    end
    compared++;
    if (cap_q.size() != 2 || cap_q[1] !== 16'h04FF) begin
      mismatched++;
      $display("FAIL blank_next got %h want 04ff", (cap_q.size() > 1) ? cap_q[1] : 16'hxxxx);
    end
  endtask

  task automatic test_lzb();
    run_to(1990);
    in_data = 16'h0050; in_dp = 4'b0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_to(2048);
    cap_q.delete();
    run_to(2304);
`ifdef SEG_SCAN_LZB_EN
    check_scan("lzb", 16'h0103, 16'h0249, 16'h04FF, 16'h08FF);
`else
    check_scan("lzb", 16'h0103, 16'h0249, 16'h0403, 16'h0803);
`endif
  endtask

  task automatic test_random();
    while (n < 3328) begin
      in_valid = ($urandom_range(7) == 0);
      in_data  = 16'($urandom);
      in_dp    = 4'($urandom);
      if ($urandom_range(15) == 0) blank = ~blank;
      step();
    end
    in_valid = 1'b0; blank = 1'b0;
  endtask

  task automatic test_midreset();
    run_to(3328 + 128 + 36 + 1);
    test_reset(1);
    run_to(256);
    check_scan("midreset", 16'h0103, 16'h0203, 16'h0403, 16'h0803);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_dp = '0; in_valid = 1'b0; blank = 1'b0;
    n = 0; xfers = 0; cap = '0;
    test_reset(3);
    test_idle();
    test_update();
    test_back_to_back();
    test_blank();
    test_lzb();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
